// File: rtl/messbauer_channel_sequencer.sv
// Frame/channel sequencer: frame start pulse, per-channel disc_start request and channel advance pulse.
// Latency: start rises one cycle after run is sampled high in IDLE; every channel lasts CHANNEL_DURATION cycles.
// Backpressure: none; disc_done is only monitored, and a channel closing without it sets the sticky overrun flag.
module messbauer_channel_sequencer #(
   parameter int CHANNEL_NUMBER      = 512,
   parameter int CHANNEL_INDEX_WIDTH = 10,
   parameter int CHANNEL_DURATION    = 1000,
   parameter int CHANNEL_PULSE_WIDTH = 10,
   parameter int START_DURATION      = 10,
   parameter int FRAME_LIMIT         = 0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic                           run,
   input  logic                           disc_done,
   output logic                           start,
   output logic                           channel,
   output logic                           disc_start,
   output logic [CHANNEL_INDEX_WIDTH-1:0] channel_index,
   output logic [15:0]                    frame_count,
   output logic                           busy,
   output logic                           overrun
);

   localparam logic [1:0] ST_IDLE          = 2'd0;
   localparam logic [1:0] ST_START_PHASE   = 2'd1;
   localparam logic [1:0] ST_CHANNEL_OPEN  = 2'd2;
   localparam logic [1:0] ST_CHANNEL_PULSE = 2'd3;

   // The duration counter is loaded with (length - 1) on state entry and the state is left when it hits 0.
   localparam logic [15:0] START_RELOAD = 16'(START_DURATION - 1);
   localparam logic [15:0] OPEN_RELOAD  = 16'(CHANNEL_DURATION - CHANNEL_PULSE_WIDTH - 1);
   localparam logic [15:0] PULSE_RELOAD = 16'(CHANNEL_PULSE_WIDTH - 1);
   localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_INDEX = CHANNEL_INDEX_WIDTH'(CHANNEL_NUMBER - 1);
   localparam logic [15:0] LIMIT_VALUE  = 16'(FRAME_LIMIT);
   localparam logic        LIMIT_EN     = (FRAME_LIMIT != 0);

   logic [1:0]  state;
   logic [15:0] dur_cnt;
   logic        done_seen;
   logic        limit_hold;   // frame limit hit with run still high: wait for run to drop before re-arming

   logic        cnt_zero;
   logic        done_any;
   logic [15:0] frame_next;
   logic        limit_hit;

   // Helper decodes: done_any covers a disc_done arriving on the very cycle the channel closes.
   always_comb begin
      cnt_zero   = (dur_cnt == 16'd0);
      done_any   = done_seen | disc_done;
      frame_next = (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;
      limit_hit  = LIMIT_EN && (frame_next == LIMIT_VALUE);
   end

   assign busy = (state != ST_IDLE);

   // Sequencer FSM; all pulse outputs are registered alongside the state transitions.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= ST_IDLE;
         dur_cnt       <= 16'd0;
         done_seen     <= 1'b0;
         limit_hold    <= 1'b0;
         start         <= 1'b0;
         channel       <= 1'b0;
         disc_start    <= 1'b0;
         channel_index <= '0;
         frame_count   <= 16'd0;
         overrun       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               start      <= 1'b0;
               channel    <= 1'b0;
               disc_start <= 1'b0;
               if (!run) begin
                  limit_hold <= 1'b0;
               end else if (!limit_hold) begin
                  state         <= ST_START_PHASE;
                  dur_cnt       <= START_RELOAD;
                  start         <= 1'b1;
                  frame_count   <= 16'd0;
                  overrun       <= 1'b0;
                  channel_index <= '0;
               end
            end

            ST_START_PHASE: begin
               if (cnt_zero) begin
                  state      <= ST_CHANNEL_OPEN;
                  dur_cnt    <= OPEN_RELOAD;
                  start      <= 1'b0;
                  disc_start <= 1'b1;
                  done_seen  <= 1'b0;
               end else begin
                  dur_cnt <= dur_cnt - 16'd1;
               end
            end

            ST_CHANNEL_OPEN: begin
               disc_start <= 1'b0;
               done_seen  <= done_any;
               if (cnt_zero) begin
                  state   <= ST_CHANNEL_PULSE;
                  dur_cnt <= PULSE_RELOAD;
                  channel <= 1'b1;
                  if (!done_any) begin
                     overrun <= 1'b1;
                  end
               end else begin
                  dur_cnt <= dur_cnt - 16'd1;
               end
            end

            ST_CHANNEL_PULSE: begin
               if (cnt_zero) begin
                  channel <= 1'b0;
                  if (channel_index < LAST_INDEX) begin
                     channel_index <= channel_index + CHANNEL_INDEX_WIDTH'(1);
                     state         <= ST_CHANNEL_OPEN;
                     dur_cnt       <= OPEN_RELOAD;
                     disc_start    <= 1'b1;
                     done_seen     <= 1'b0;
                  end else begin
                     frame_count   <= frame_next;
                     channel_index <= '0;
                     if (!run || limit_hit) begin
                        state      <= ST_IDLE;
                        limit_hold <= run && limit_hit;
                     end else begin
                        state   <= ST_START_PHASE;
                        dur_cnt <= START_RELOAD;
                        start   <= 1'b1;
                     end
                  end
               end else begin
                  dur_cnt <= dur_cnt - 16'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// Bench for messbauer_channel_sequencer: two instances (unlimited and single-frame limit) share stimulus.
// Latency: a per-cycle expectation is queued at each rising edge and checked at the following falling edge.
// Backpressure: none; disc_done is generated from directed patterns or at random.
module tb_messbauer_channel_sequencer;

   localparam int CN   = 4;
   localparam int IW   = 3;
   localparam int CD   = 20;
   localparam int PW   = 3;
   localparam int SD   = 2;
   localparam int OPEN = CD - PW;
   localparam int FLEN = SD + CN * CD;

   typedef struct packed {
      logic          start;
      logic          channel;
      logic          disc_start;
      logic [IW-1:0] idx;
      logic [15:0]   fc;
      logic          busy;
      logic          ovr;
   } obs_t;

   logic aclk = 1'b0;
   logic areset;
   logic run;
   logic disc_done;

   logic          start0, channel0, ds0, busy0, ovr0;
   logic [IW-1:0] idx0;
   logic [15:0]   fc0;
   logic          start1, channel1, ds1, busy1, ovr1;
   logic [IW-1:0] idx1;
   logic [15:0]   fc1;
   obs_t          act0, act1;

   int checks = 0;
   int errors = 0;

   messbauer_channel_sequencer #(
      .CHANNEL_NUMBER(CN), .CHANNEL_INDEX_WIDTH(IW), .CHANNEL_DURATION(CD),
      .CHANNEL_PULSE_WIDTH(PW), .START_DURATION(SD), .FRAME_LIMIT(0)
   ) dut0 (
      .aclk(aclk), .areset(areset), .run(run), .disc_done(disc_done),
      .start(start0), .channel(channel0), .disc_start(ds0), .channel_index(idx0),
      .frame_count(fc0), .busy(busy0), .overrun(ovr0)
   );

   messbauer_channel_sequencer #(
      .CHANNEL_NUMBER(CN), .CHANNEL_INDEX_WIDTH(IW), .CHANNEL_DURATION(CD),
      .CHANNEL_PULSE_WIDTH(PW), .START_DURATION(SD), .FRAME_LIMIT(1)
   ) dut1 (
      .aclk(aclk), .areset(areset), .run(run), .disc_done(disc_done),
      .start(start1), .channel(channel1), .disc_start(ds1), .channel_index(idx1),
      .frame_count(fc1), .busy(busy1), .overrun(ovr1)
   );

   assign act0 = {start0, channel0, ds0, idx0, fc0, busy0, ovr0};
   assign act1 = {start1, channel1, ds1, idx1, fc1, busy1, ovr1};

   initial forever #5 aclk = ~aclk;

   // ---------------- reference model: frame timeline by offset arithmetic ----------------
   bit m_active [2];
   bit m_hold   [2];
   bit m_seen   [2];
   bit m_ovr    [2];
   int m_o      [2];   // offset within the frame of the cycle currently in progress
   int m_fc     [2];
   obs_t q0 [$];
   obs_t q1 [$];

   function automatic obs_t predict(int i);
      obs_t e;
      int   k;
      int   r;
      e     = '0;
      e.fc  = 16'(m_fc[i]);
      e.ovr = m_ovr[i];
      if (m_active[i]) begin
         e.busy = 1'b1;
         if (m_o[i] < SD) begin
            e.start = 1'b1;
         end else begin
            k            = (m_o[i] - SD) / CD;
            r            = (m_o[i] - SD) % CD;
            e.idx        = IW'(k);
            e.disc_start = (r == 0);
            e.channel    = (r >= OPEN);
         end
      end
      return e;
   endfunction

   function automatic void step(int i, int lim);
      int r;
      if (areset) begin
         m_active[i] = 0; m_hold[i] = 0; m_seen[i] = 0; m_ovr[i] = 0; m_o[i] = 0; m_fc[i] = 0;
      end else if (!m_active[i]) begin
         if (!run) m_hold[i] = 0;
         else if (!m_hold[i]) begin
            m_active[i] = 1; m_o[i] = 0; m_fc[i] = 0; m_ovr[i] = 0;
         end
      end else begin
         if (m_o[i] >= SD) begin
            r = (m_o[i] - SD) % CD;
            if (r == 0) m_seen[i] = 0;
            if (r < OPEN) m_seen[i] = m_seen[i] | disc_done;
            if (r == OPEN - 1 && !m_seen[i]) m_ovr[i] = 1;
         end
         if (m_o[i] == FLEN - 1) begin
            if (m_fc[i] < 65535) m_fc[i] = m_fc[i] + 1;
            if (!run || (lim != 0 && m_fc[i] == lim)) begin
               m_active[i] = 0;
               m_hold[i]   = run && lim != 0 && m_fc[i] == lim;
            end else begin
               m_o[i] = 0;
            end
         end else begin
            m_o[i] = m_o[i] + 1;
         end
      end
   endfunction

   initial forever begin
      @(posedge aclk);
      step(0, 0);
      step(1, 1);
      q0.push_back(predict(0));
      q1.push_back(predict(1));
   end

   // ---------------- monitor ----------------
   task automatic compare(input int i, input obs_t a);
      obs_t e;
      checks++;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
         errors++;
         $display("FAIL sb_empty dut%0d t=%0t: no expectation queued", i, $time);
      end else begin
         e = (i == 0) ? q0.pop_front() : q1.pop_front();
         if (areset) e = '0;
         if (a !== e) begin
            errors++;
            $display("FAIL sb_dut%0d t=%0t got st=%b ch=%b ds=%b idx=%0d fc=%0d busy=%b ovr=%b required st=%b ch=%b ds=%b idx=%0d fc=%0d busy=%b ovr=%b",
                     i, $time, a.start, a.channel, a.disc_start, a.idx, a.fc, a.busy, a.ovr,
                     e.start, e.channel, e.disc_start, e.idx, e.fc, e.busy, e.ovr);
         end
      end
   endtask

   initial forever begin
      @(negedge aclk);
      compare(0, act0);
      compare(1, act1);
   end

   // ---------------- directed counters on the single-frame instance ----------------
   bit count_en = 0;
   int busy_cnt = 0;
   int start_cnt = 0;
   int ds_cnt = 0;

   initial forever begin
      @(negedge aclk);
      if (count_en) begin
         busy_cnt  += int'(busy1);
         start_cnt += int'(start1);
         ds_cnt    += int'(ds1);
      end
   end

   task automatic chk(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, a, e);
      end
   endtask

   // ---------------- disc_done generator ----------------
   int done_mode = 0;
   bit skip_ch2  = 0;
   int since_ds  = 100;

   initial begin
      disc_done = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         since_ds = ds1 ? 0 : ((since_ds < 1000) ? since_ds + 1 : since_ds);
         case (done_mode)
            1:       disc_done = (since_ds == 5) && !(skip_ch2 && idx1 == IW'(2));
            2:       disc_done = ($urandom_range(0, 5) == 0);
            3:       disc_done = channel0 | start0;
            default: disc_done = 1'b0;
         endcase
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      areset = 1'b1;
      run    = 1'b0;
      cyc(5);
      areset = 1'b0;
      cyc(20);
      chk("reset_busy0", int'(busy0), 0);
      chk("reset_busy1", int'(busy1), 0);
      chk("reset_fc0", int'(fc0), 0);

      // single frame with done 5 cycles after each disc_start
      done_mode = 1;
      count_en  = 1;
      run       = 1'b1;
      cyc(120);
      count_en  = 0;
      chk("single_busy_cycles", busy_cnt, FLEN);
      chk("single_start_cycles", start_cnt, SD);
      chk("single_disc_starts", ds_cnt, CN);
      chk("single_fc", int'(fc1), 1);
      chk("single_ovr", int'(ovr1), 0);
      chk("single_hold_idle", int'(busy1), 0);
      run = 1'b0;
      cyc(10);

      // missing done on channel 2
      skip_ch2 = 1;
      run      = 1'b1;
      cyc(120);
      chk("missing_ovr", int'(ovr1), 1);
      run = 1'b0;
      cyc(10);
      chk("missing_ovr_sticky", int'(ovr1), 1);
      skip_ch2 = 0;
      run      = 1'b1;
      cyc(5);
      chk("missing_ovr_cleared", int'(ovr1), 0);
      run = 1'b0;
      cyc(100);

      // graceful stop during channel 1
      run = 1'b1;
      cyc(SD + CD + 5);
      run = 1'b0;
      cyc(100);
      chk("graceful_fc0", int'(fc0), 1);
      chk("graceful_busy0", int'(busy0), 0);

      // continuous run for 3 frames with random done
      done_mode = 2;
      run       = 1'b1;
      cyc(3 * FLEN - 10);
      run = 1'b0;
      cyc(30);
      chk("continuous_fc0", int'(fc0), 3);
      chk("continuous_busy0", int'(busy0), 0);

      // done only during channel pulses: every channel overruns
      done_mode = 3;
      run       = 1'b1;
      cyc(20);
      run = 1'b0;
      cyc(100);
      chk("pulse_done_ovr0", int'(ovr0), 1);

      // mid-frame reset during channel 2 of frame 1
      done_mode = 1;
      run       = 1'b1;
      cyc(FLEN + SD + 2 * CD + 5);
      #2;
      areset = 1'b1;
      #1;
      chk("async_reset_dut0", int'(act0 == '0), 1);
      chk("async_reset_dut1", int'(act1 == '0), 1);
      cyc(3);
      areset = 1'b0;
      cyc(10);
      chk("after_reset_fc0", int'(fc0), 0);
      chk("after_reset_busy0", int'(busy0), 1);
      chk("after_reset_idx0", int'(idx0), 0);
      run = 1'b0;
      cyc(100);

      // randomized run/done/reset
      done_mode = 2;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 59) == 0) run = ~run;
         if ($urandom_range(0, 499) == 0) areset = 1'b1;
         else areset = 1'b0;
         cyc(1);
      end
      areset = 1'b0;
      run    = 1'b0;
      cyc(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
